// File: rtl/modred_pkg.sv
// Shared types and sizing helpers for the modred_shift Montgomery-domain reducer.
package modred_pkg;

    localparam int unsigned MODRED_DEFAULT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter width able to hold W + (2^len_w - 1) remaining steps.
    function automatic int unsigned cnt_width(input int unsigned w, input int unsigned len_w);
        return $clog2(w + (32'd1 << len_w));
    endfunction

endpackage

// File: rtl/modred_step.sv
// One shift-compare-subtract step of the serial reducer: r_next = ({r,bit} >= m) ? {r,bit}-m : {r,bit}.
module modred_step
    import modred_pkg::*;
#(
    parameter int unsigned W = MODRED_DEFAULT_W
) (
    input  logic [W:0]   r_i,
    input  logic         bit_i,
    input  logic [W-1:0] m_i,
    output logic [W:0]   r_next_o_c
);

    logic [W+1:0] t;
    logic [W+1:0] m_ext;

    // Carried one bit wider than r so the compare never truncates.
    always_comb begin
        t          = {r_i, bit_i};
        m_ext      = {2'b00, m_i};
        r_next_o_c = (t >= m_ext) ? (W+1)'(t - m_ext) : (W+1)'(t);
    end

endmodule

// File: rtl/modred_shift.sv
// Serial reducer computing (num_in * 2^len) mod modulus; define MODRED_RADIX4_EN for two steps per cycle.
module modred_shift
    import modred_pkg::*;
#(
    parameter int unsigned W     = MODRED_DEFAULT_W,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             md_start,
    input  logic [LEN_W-1:0] len,
    input  logic [W-1:0]     num_in,
    input  logic [W-1:0]     modulus,
    output logic             md_end,
    output logic [W-1:0]     ld_out,
    output logic             busy,
    output logic             err_div0
);

    localparam int unsigned CW = cnt_width(W, LEN_W);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   sh_q, sh_d;
    logic [W:0]     r_q, r_d;
    logic [W-1:0]   m_q, m_d;
    logic [W-1:0]   ld_q, ld_d;
    logic           err_q, err_d;
    logic           md_end_q, md_end_d;
    logic           busy_q, busy_d;

    logic [W:0]     r_s1;
    logic [W:0]     r_step;
    logic [W-1:0]   sh_next;
    logic [CW-1:0]  cnt_init;

    modred_step #(.W(W)) u_step0 (
        .r_i        (r_q),
        .bit_i      (sh_q[W-1]),
        .m_i        (m_q),
        .r_next_o_c (r_s1)
    );

`ifdef MODRED_RADIX4_EN
    localparam int unsigned TW = CW + 1;

    logic           odd_q, odd_d;
    logic [W:0]     r_s2;
    logic [TW-1:0]  total;

    modred_step #(.W(W)) u_step1 (
        .r_i        (r_s1),
        .bit_i      (sh_q[W-2]),
        .m_i        (m_q),
        .r_next_o_c (r_s2)
    );

    // An odd stream length leaves a single step for the final RUN cycle.
    always_comb begin
        total    = TW'(W) + TW'(len);
        cnt_init = CW'((total + TW'(1)) >> 1);
        r_step   = ((cnt_q == CW'(1)) && odd_q) ? r_s1 : r_s2;
        sh_next  = {sh_q[W-3:0], 2'b00};
    end
`else
    always_comb begin
        cnt_init = CW'(W) + CW'(len);
        r_step   = r_s1;
        sh_next  = {sh_q[W-2:0], 1'b0};
    end
`endif

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        r_d     = r_q;
        m_d     = m_q;
        ld_d    = ld_q;
        err_d   = err_q;
`ifdef MODRED_RADIX4_EN
        odd_d   = odd_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (md_start) begin
                    m_d   = modulus;
                    sh_d  = num_in;
                    r_d   = '0;
                    err_d = 1'b0;
                    cnt_d = cnt_init;
`ifdef MODRED_RADIX4_EN
                    odd_d = total[0];
`endif
                    if (modulus == '0) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                        ld_d    = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                r_d   = r_step;
                sh_d  = sh_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                    ld_d    = r_step[W-1:0];
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        md_end_d = (state_d == ST_DONE);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            r_q      <= '0;
            m_q      <= '0;
            ld_q     <= '0;
            err_q    <= 1'b0;
            md_end_q <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MODRED_RADIX4_EN
            odd_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            r_q      <= r_d;
            m_q      <= m_d;
            ld_q     <= ld_d;
            err_q    <= err_d;
            md_end_q <= md_end_d;
            busy_q   <= busy_d;
`ifdef MODRED_RADIX4_EN
            odd_q    <= odd_d;
`endif
        end
    end

    assign md_end   = md_end_q;
    assign ld_out   = ld_q;
    assign busy     = busy_q;
    assign err_div0 = err_q;

endmodule

// File: tb/tb_modred_shift.sv
// Scoreboard bench for modred_shift: directed vectors, expected results pushed at issue, checked on md_end.
module tb_modred_shift;

    localparam int unsigned W     = 32;
    localparam int unsigned LEN_W = 8;
    localparam int          NVEC  = 9;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             md_start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic [W-1:0]     num_in = '0;
    logic [W-1:0]     modulus = '0;
    logic             md_end;
    logic [W-1:0]     ld_out;
    logic             busy;
    logic             err_div0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           end_cyc;
    } exp_t;

    exp_t sb[$];

    logic [W-1:0]     v_num [NVEC] = '{32'd12345, 32'd0, 32'd100, 32'hFFFFFFFF, 32'd1,
                                       32'h80000000, 32'd7, 32'h12345678, 32'd5};
    logic [LEN_W-1:0] v_len [NVEC] = '{8'd255, 8'd255, 8'd0, 8'd0, 8'd255,
                                       8'd1, 8'd5, 8'd0, 8'd2};
    logic [W-1:0]     v_mod [NVEC] = '{32'd1, 32'd97, 32'd7, 32'h00010000, 32'd3,
                                       32'hFFFFFFFF, 32'd1000, 32'h12345678, 32'h80000000};
    logic [W-1:0]     v_exp [NVEC] = '{32'd0, 32'd0, 32'd2, 32'h0000FFFF, 32'd2,
                                       32'd1, 32'd224, 32'd0, 32'd20};

    modred_shift #(.W(W), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .md_start (md_start),
        .len      (len),
        .num_in   (num_in),
        .modulus  (modulus),
        .md_end   (md_end),
        .ld_out   (ld_out),
        .busy     (busy),
        .err_div0 (err_div0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Edges from the start-sampling edge to the md_end cycle.
    function automatic int lat(input logic [LEN_W-1:0] l, input logic [W-1:0] m);
        if (m == '0) return 1;
`ifdef MODRED_RADIX4_EN
        return (int'(W) + int'(l) + 1) / 2 + 1;
`else
        return int'(W) + int'(l) + 1;
`endif
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic issue(input logic [W-1:0] n, input logic [LEN_W-1:0] l,
                         input logic [W-1:0] m, input logic [W-1:0] ex,
                         input logic e, input bit push);
        @(negedge clk);
        num_in   = n;
        len      = l;
        modulus  = m;
        md_start = 1'b1;
        if (push) sb.push_back('{ex, e, cyc + lat(l, m)});
        @(negedge clk);
        md_start = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 700 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: %0d results outstanding, want 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bit busy_ok;
        int s;
        int la;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (rstn && md_end === 1'b1) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL spurious_md_end: md_end=1 at cycle %0d, want 0", cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("ld_out", ld_out, e.res);
                        chk("err_div0", W'(err_div0), W'(e.err));
                        chk("md_end_cycle", W'(cyc), W'(e.end_cyc));
                        chk("busy_at_end", W'(busy), W'(1));
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_ld_out", ld_out, '0);
        chk("rst_md_end", W'(md_end), '0);
        chk("rst_busy", W'(busy), '0);
        chk("rst_err", W'(err_div0), '0);
        rstn = 1'b1;
        @(negedge clk);

        // Basic operation with busy window.
        issue(32'd10, 8'd4, 32'd11, 32'd6, 1'b0, 1'b1);
        busy_ok = 1'b1;
        for (int k = 1; k <= lat(8'd4, 32'd11); k++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
        end
        chk("busy_window", W'(busy_ok), W'(1));
        chk("busy_after", W'(busy), '0);
        wait_done();

        // Back-to-back with md_start held and inputs changed mid-run.
        @(negedge clk);
        num_in   = 32'd15;
        len      = 8'd3;
        modulus  = 32'd7;
        md_start = 1'b1;
        s  = cyc;
        la = lat(8'd3, 32'd7);
        sb.push_back('{32'd1, 1'b0, s + la});
        sb.push_back('{32'd10, 1'b0, s + la + 1 + lat(8'd4, 32'd13)});
        @(negedge clk);
        num_in  = 32'd25;
        len     = 8'd4;
        modulus = 32'd13;
        repeat (la + 1) @(negedge clk);
        md_start = 1'b0;
        wait_done();

        // Full-width operands with num_in >= m.
        issue(32'hFFFFFFFF, 8'd32, 32'hFFFFFFFB, 32'd20, 1'b0, 1'b1);
        wait_done();

        // Divide by zero, then a valid start clears the flag.
        issue(32'd10, 8'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        wait_done();
        chk("div0_err_held", W'(err_div0), W'(1));
        chk("div0_ld_held", ld_out, '0);
        issue(32'd100, 8'd0, 32'd7, 32'd2, 1'b0, 1'b1);
        wait_done();

        for (int i = 0; i < NVEC; i++) begin
            issue(v_num[i], v_len[i], v_mod[i], v_exp[i], 1'b0, 1'b1);
            wait_done();
        end

        // Start pulse during a run is ignored.
        issue(32'd10, 8'd4, 32'd11, 32'd6, 1'b0, 1'b1);
        repeat (9) @(negedge clk);
        num_in   = 32'd999;
        len      = 8'd9;
        modulus  = 32'd5;
        md_start = 1'b1;
        @(negedge clk);
        md_start = 1'b0;
        wait_done();
        repeat (45) @(negedge clk);

        // Reset mid-run aborts with no completion.
        issue(32'd25, 8'd4, 32'd13, 32'd0, 1'b0, 1'b0);
        repeat (19) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("abort_ld_out", ld_out, '0);
        chk("abort_busy", W'(busy), '0);
        chk("abort_md_end", W'(md_end), '0);
        chk("abort_err", W'(err_div0), '0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (45) @(negedge clk);
        issue(32'd25, 8'd4, 32'd13, 32'd10, 1'b0, 1'b1);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
